// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU operation codes and default datapath width for the
//               decode/execute pipeline boundary.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_dw_default = 32;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0011;
    localparam logic [3:0] c_alu_slt = 4'b0100;
    localparam logic [3:0] c_alu_sll = 4'b0101;
    localparam logic [3:0] c_alu_srl = 4'b0110;
    localparam logic [3:0] c_alu_sra = 4'b0111;
    localparam logic [3:0] c_alu_xor = 4'b1001;
    localparam logic [3:0] c_alu_nor = 4'b1010;
    localparam logic [3:0] c_alu_nop = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel
// Description : Operand forwarding selector. Picks the youngest in-flight
//               result whose destination matches the operand index; index 0
//               is hard-wired and never forwarded. With ID_EX_FORWARD_EN
//               undefined the register-file value passes straight through.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
    import alu_pkg::*;
#(
    parameter int DW = c_dw_default,
    parameter int RW = 5
) (
    input  logic [RW-1:0] i_idx,
    input  logic [DW-1:0] i_rf_data,
    input  logic          i_exmem_reg_write,
    input  logic [RW-1:0] i_exmem_rd,
    input  logic [DW-1:0] i_exmem_data,
    input  logic          i_memwb_reg_write,
    input  logic [RW-1:0] i_memwb_rd,
    input  logic [DW-1:0] i_memwb_data,
    output logic [DW-1:0] o_data
);

`ifdef ID_EX_FORWARD_EN
    logic w_idx_live;
    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_idx_live  = |i_idx;
    assign w_hit_exmem = w_idx_live && i_exmem_reg_write && (i_exmem_rd == i_idx);
    assign w_hit_memwb = w_idx_live && i_memwb_reg_write && (i_memwb_rd == i_idx);

    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    always_comb begin
        o_data = i_rf_data;
        if (w_hit_exmem) begin
            o_data = i_exmem_data;
        end else if (w_hit_memwb) begin
            o_data = i_memwb_data;
        end
    end
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{i_idx, i_exmem_reg_write, i_exmem_rd, i_exmem_data,
                            i_memwb_reg_write, i_memwb_rd, i_memwb_data};
    assign o_data       = i_rf_data;
`endif

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg
// Description : ID/EX pipeline register with flush > stall > load priority.
//               Operands are forwarded on load and re-forwarded from the held
//               indices while stalled. Forwarding is enabled by defining
//               ID_EX_FORWARD_EN; otherwise forwarding ports are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg
    import alu_pkg::*;
#(
    parameter int DW = c_dw_default,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_rs_data,
    input  logic [DW-1:0] in_rt_data,
    input  logic [DW-1:0] in_imm,
    input  logic          in_use_imm,
    input  logic [3:0]    in_sel,
    input  logic [4:0]    in_shamt,
    input  logic [RW-1:0] in_rs,
    input  logic [RW-1:0] in_rt,
    input  logic [RW-1:0] in_rd,
    input  logic          in_reg_write,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_data,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic          out_valid,
    output logic [DW-1:0] data_1,
    output logic [DW-1:0] data_2,
    output logic [3:0]    sel,
    output logic [4:0]    shamt,
    output logic [DW-1:0] store_data,
    output logic [RW-1:0] out_rd,
    output logic          out_reg_write
);

    logic          r_valid;
    logic [DW-1:0] r_data_1;
    logic [DW-1:0] r_data_2;
    logic [DW-1:0] r_store_data;
    logic [3:0]    r_sel;
    logic [4:0]    r_shamt;
    logic [RW-1:0] r_rd;
    logic          r_reg_write;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic          r_use_imm;

    logic          w_bubble;
    logic [RW-1:0] w_rs_idx;
    logic [RW-1:0] w_rt_idx;
    logic [DW-1:0] w_rs_base;
    logic [DW-1:0] w_rt_base;
    logic [DW-1:0] w_rs_fwd;
    logic [DW-1:0] w_rt_fwd;

    // While stalled the selectors look at the held indices and held operands,
    // so the same two selectors serve both the load and the stall path.
    assign w_rs_idx  = stall ? r_rs         : in_rs;
    assign w_rt_idx  = stall ? r_rt         : in_rt;
    assign w_rs_base = stall ? r_data_1     : in_rs_data;
    assign w_rt_base = stall ? r_store_data : in_rt_data;

    // A load of an empty slot is indistinguishable from a flush.
    assign w_bubble  = flush || (!stall && !in_valid);

    fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rs (
        .i_idx             (w_rs_idx),
        .i_rf_data         (w_rs_base),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_data      (exmem_data),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_data      (memwb_data),
        .o_data            (w_rs_fwd)
    );

    fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rt (
        .i_idx             (w_rt_idx),
        .i_rf_data         (w_rt_base),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_data      (exmem_data),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_data      (memwb_data),
        .o_data            (w_rt_fwd)
    );

    // Pipeline register: async bubble on reset, then flush > stall > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_data_1     <= '0;
            r_data_2     <= '0;
            r_store_data <= '0;
            r_sel        <= c_alu_nop;
            r_shamt      <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_use_imm    <= 1'b0;
        end else if (w_bubble) begin
            r_valid      <= 1'b0;
            r_data_1     <= '0;
            r_data_2     <= '0;
            r_store_data <= '0;
            r_sel        <= c_alu_nop;
            r_shamt      <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_use_imm    <= 1'b0;
        end else if (stall) begin
            // Only a live instruction picks up late results; a bubble stays put.
            if (r_valid) begin
                r_data_1     <= w_rs_fwd;
                r_store_data <= w_rt_fwd;
                if (!r_use_imm) begin
                    r_data_2 <= w_rt_fwd;
                end
            end
        end else begin
            r_valid      <= 1'b1;
            r_data_1     <= w_rs_fwd;
            r_data_2     <= in_use_imm ? in_imm : w_rt_fwd;
            r_store_data <= w_rt_fwd;
            r_sel        <= in_sel;
            r_shamt      <= in_shamt;
            r_rd         <= in_rd;
            r_reg_write  <= in_reg_write;
            r_rs         <= in_rs;
            r_rt         <= in_rt;
            r_use_imm    <= in_use_imm;
        end
    end

    assign out_valid     = r_valid;
    assign data_1        = r_data_1;
    assign data_2        = r_data_2;
    assign store_data    = r_store_data;
    assign sel           = r_sel;
    assign shamt         = r_shamt;
    assign out_rd        = r_rd;
    assign out_reg_write = r_reg_write;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_reg
// Description : Self-checking bench for id_ex_reg: directed scenarios plus
//               randomized traffic against a behavioural reference model.
//               Follows ID_EX_FORWARD_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

    localparam int DW = 32;
    localparam int RW = 5;

`ifdef ID_EX_FORWARD_EN
    localparam bit c_fwd = 1'b1;
`else
    localparam bit c_fwd = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          stall, flush, in_valid, in_use_imm, in_reg_write;
    logic [DW-1:0] in_rs_data, in_rt_data, in_imm;
    logic [3:0]    in_sel;
    logic [4:0]    in_shamt;
    logic [RW-1:0] in_rs, in_rt, in_rd;
    logic          exmem_reg_write, memwb_reg_write;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [DW-1:0] exmem_data, memwb_data;
    logic          out_valid, out_reg_write;
    logic [DW-1:0] data_1, data_2, store_data;
    logic [3:0]    sel;
    logic [4:0]    shamt;
    logic [RW-1:0] out_rd;

    always #5 clk = ~clk;

    id_ex_reg #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sel(in_sel),
        .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .exmem_reg_write(exmem_reg_write),
        .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_data(memwb_data), .out_valid(out_valid), .data_1(data_1),
        .data_2(data_2), .sel(sel), .shamt(shamt), .store_data(store_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] sd;
        logic [3:0]  sel;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rw;
        logic        use_imm;
    } mstate_t;

    mstate_t     m;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  saved_sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value an operand should carry: youngest matching writer, never register 0.
    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (!c_fwd || idx == 5'd0) return rf;
        if (exmem_reg_write && exmem_rd == idx) return exmem_data;
        if (memwb_reg_write && memwb_rd == idx) return memwb_data;
        return rf;
    endfunction

    task automatic model_bubble();
        m     = '0;
        m.sel = 4'hF;
    endtask

    task automatic model_edge();
        mstate_t n;
        n = m;
        if (!rst_n || flush || (!stall && !in_valid)) begin
            n     = '0;
            n.sel = 4'hF;
        end else if (stall) begin
            if (m.valid) begin
                n.d1 = fwd(m.rs, m.d1);
                n.sd = fwd(m.rt, m.sd);
                if (!m.use_imm) n.d2 = fwd(m.rt, m.d2);
            end
        end else begin
            n.valid   = 1'b1;
            n.d1      = fwd(in_rs, in_rs_data);
            n.sd      = fwd(in_rt, in_rt_data);
            n.d2      = in_use_imm ? in_imm : n.sd;
            n.sel     = in_sel;
            n.shamt   = in_shamt;
            n.rd      = in_rd;
            n.rw      = in_reg_write;
            n.rs      = in_rs;
            n.rt      = in_rt;
            n.use_imm = in_use_imm;
        end
        m = n;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".valid"},  32'(out_valid),     32'(m.valid));
        chk({ctx, ".data_1"}, data_1,             m.d1);
        chk({ctx, ".data_2"}, data_2,             m.d2);
        chk({ctx, ".store"},  store_data,         m.sd);
        chk({ctx, ".sel"},    32'(sel),           32'(m.sel));
        chk({ctx, ".shamt"},  32'(shamt),         32'(m.shamt));
        chk({ctx, ".rd"},     32'(out_rd),        32'(m.rd));
        chk({ctx, ".rw"},     32'(out_reg_write), 32'(m.rw));
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; in_valid = 0; in_use_imm = 0; in_reg_write = 0;
        in_rs_data = '0; in_rt_data = '0; in_imm = '0; in_sel = 4'h0; in_shamt = '0;
        in_rs = '0; in_rt = '0; in_rd = '0;
        exmem_reg_write = 0; exmem_rd = '0; exmem_data = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_data = '0;
    endtask

    task automatic rand_inputs();
        in_valid        = ($urandom_range(0, 9) != 0);
        stall           = ($urandom_range(0, 3) == 0);
        flush           = ($urandom_range(0, 11) == 0);
        in_rs_data      = $urandom;
        in_rt_data      = $urandom;
        in_imm          = $urandom;
        in_use_imm      = 1'($urandom_range(0, 1));
        in_sel          = 4'($urandom_range(0, 15));
        in_shamt        = 5'($urandom_range(0, 31));
        in_rs           = 5'($urandom_range(0, 3));
        in_rt           = 5'($urandom_range(0, 3));
        in_rd           = 5'($urandom_range(0, 31));
        in_reg_write    = 1'($urandom_range(0, 1));
        exmem_reg_write = 1'($urandom_range(0, 1));
        exmem_rd        = 5'($urandom_range(0, 3));
        exmem_data      = $urandom;
        memwb_reg_write = 1'($urandom_range(0, 1));
        memwb_rd        = 5'($urandom_range(0, 3));
        memwb_data      = $urandom;
    endtask

    task automatic mid_cycle_reset(input string ctx);
        #2 rst_n = 1'b0;
        #1;
        model_bubble();
        chk({ctx, ".async_valid"}, 32'(out_valid), 32'd0);
        chk({ctx, ".async_sel"},   32'(sel),       32'hF);
        chk({ctx, ".async_d1"},    data_1,         32'd0);
        check_all(ctx);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_bubble();

        // Reset asserted with no clock edge yet.
        #2 rst_n = 1'b0;
        #1;
        check_all("reset");
        step("reset_edge");
        #1 rst_n = 1'b1;

        // EX/MEM and MEM/WB both match rs: EX/MEM wins.
        in_valid = 1; in_rs = 5'd3; in_rs_data = 32'd5;
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_data = 32'h10;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_data = 32'h20;
        in_rt = 5'd1; in_rt_data = 32'h33; in_sel = 4'b0010;
        step("both_match");
        chk("both_match.d1", data_1, c_fwd ? 32'h10 : 32'h5);

        // Register 0 never forwards.
        idle_inputs();
        in_valid = 1; in_rt = 5'd0; in_rt_data = 32'd7;
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_data = 32'd9;
        step("zero_idx");
        chk("zero_idx.store", store_data, 32'd7);
        chk("zero_idx.d2",    data_2,     32'd7);

        // Load rs=4, stall twice, late MEM/WB result arrives on second stall.
        idle_inputs();
        in_valid = 1; in_rs = 5'd4; in_rs_data = 32'd1; in_sel = 4'b0011;
        in_rt = 5'd2; in_rt_data = 32'h44; in_rd = 5'd9; in_reg_write = 1;
        step("stall_load");
        saved_sel = 4'b0011;
        rand_inputs();
        stall = 1; flush = 0; exmem_reg_write = 0; memwb_reg_write = 0;
        step("stall_1");
        chk("stall_1.d1", data_1, 32'd1);
        exmem_reg_write = 0;
        memwb_reg_write = 1; memwb_rd = 5'd4; memwb_data = 32'hAB;
        step("stall_2");
        chk("stall_2.d1",  data_1,     c_fwd ? 32'hAB : 32'd1);
        chk("stall_2.sel", 32'(sel),   32'(saved_sel));

        // Flush beats stall on the same edge.
        idle_inputs();
        stall = 1; flush = 1; in_valid = 1; in_sel = 4'b0001;
        step("flush_stall");
        chk("flush_stall.valid", 32'(out_valid), 32'd0);
        chk("flush_stall.sel",   32'(sel),       32'hF);

        // Stall on a bubble leaves it untouched even with a matching writer.
        idle_inputs();
        stall = 1; exmem_reg_write = 1; exmem_rd = 5'd0; exmem_data = 32'h55;
        step("stall_bubble");

        // Immediate operand path.
        idle_inputs();
        in_valid = 1; in_use_imm = 1; in_imm = 32'hFFFF_FFFC; in_sel = 4'b0010;
        in_rt = 5'd2; in_rt_data = 32'h1234;
        step("imm_load");
        chk("imm_load.d2",  data_2,   32'hFFFF_FFFC);
        chk("imm_load.sel", 32'(sel), 32'h2);

        // Async reset in the middle of live traffic, then normal reload.
        mid_cycle_reset("mid_reset");
        in_valid = 1; in_use_imm = 0;
        step("post_reset");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step("rand");
            if (i % 57 == 56) mid_cycle_reset("rand_reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DW, default 32, datapath width; parameter RW, default 5, register-index width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  hold current contents; re-forward held operands.
REQ-005 flush  input  1  replace contents with bubble.
REQ-006 in_valid  input  1  decode stage presents an instruction.
REQ-007 in_rs_data, in_rt_data  input  DW each  register-file read values.
REQ-008 in_imm  input  DW  sign/zero-extended immediate.
REQ-009 in_use_imm  input  1  data_2 takes in_imm instead of rt operand.
REQ-010 in_sel  input  4  ALU operation code; in_shamt  input  5  shift amount.
REQ-011 in_rs, in_rt, in_rd  input  RW each  source/destination indices; in_reg_write  input  1.
REQ-012 exmem_reg_write  input  1; exmem_rd  input  RW; exmem_data  input  DW  EX/MEM forwarding source.
REQ-013 memwb_reg_write  input  1; memwb_rd  input  RW; memwb_data  input  DW  MEM/WB forwarding source.
REQ-014 out_valid  output  1; data_1, data_2  output  DW  ALU operands; sel  output  4; shamt  output  5.
REQ-015 store_data  output  DW  forwarded rt value; out_rd  output  RW; out_reg_write  output  1.

Function
REQ-016 All outputs SHALL be registered; latency one clk from inputs to outputs.
REQ-017 Priority per edge SHALL be flush > stall > load.
REQ-018 flush: out_valid=0, sel=NOP (4'b1111), shamt=0, data_1/data_2/store_data=0, out_rd=0, out_reg_write=0.
REQ-019 load with in_valid=1: capture all fields, out_valid=1; data_1 = forwarded rs, store_data = forwarded rt, data_2 = in_use_imm ? in_imm : forwarded rt.
REQ-020 load with in_valid=0: identical to flush (bubble).
REQ-021 Forwarding: operand with index r SHALL take exmem_data if exmem_reg_write and exmem_rd==r, else memwb_data if memwb_reg_write and memwb_rd==r, else register-file value.
REQ-022 Index 0 SHALL never forward; value from in_rs_data/in_rt_data is used unchanged.
REQ-023 Both sources matching: EX/MEM wins.
REQ-024 stall: control fields, in_imm path and indices held; rs/rt operands held but re-forwarded per REQ-021 using stored rs/rt indices each stalled cycle; data_2 re-forwarded only if stored use_imm=0.
REQ-025 Stall with out_valid=0: contents unchanged, no forwarding applied.
REQ-026 sel SHALL be NOP and out_reg_write 0 whenever out_valid=0.

Reset
REQ-027 rst_n low SHALL immediately force bubble state of REQ-018, independent of clk.
REQ-028 Internal stored rs/rt indices and use_imm SHALL reset to 0.
REQ-029 First edge after rst_n release SHALL perform a normal load/stall/flush decision.

Configuration
REQ-030 Macro ID_EX_FORWARD_EN: defined -> forwarding per REQ-021..REQ-024.
REQ-031 Undefined -> operands taken from in_rs_data/in_rt_data only, stall holds without re-forwarding, forwarding ports present and ignored.

Structure
REQ-032 Shared package alu_pkg SHALL hold ALU op codes (AND 0000, OR 0001, ADD 0010, SUB 0011, SLT 0100, SLL 0101, SRL 0110, SRA 0111, XOR 1001, NOR 1010, NOP 1111) and DW default.
REQ-033 Sub-module fwd_sel (index, reg-file value, both forwarding sources -> selected value) SHALL be instantiated twice (rs, rt) and shared between load and stall paths.

Verification
REQ-034 rst_n=0 mid-stream -> out_valid=0, sel=4'b1111, data_1=0 without waiting for clk.
REQ-035 Load in_rs=3, in_rs_data=5, exmem_reg_write=1, exmem_rd=3, exmem_data=0x10, memwb_rd=3, memwb_data=0x20 -> data_1=0x10 next cycle.
REQ-036 Load in_rt=0, in_rt_data=7, exmem_rd=0, exmem_reg_write=1, exmem_data=9 -> store_data=7, data_2=7.
REQ-037 Load in_rs=4 (stale 1), stall 2 cycles, second cycle memwb_rd=4, memwb_data=0xAB -> data_1=0xAB, sel unchanged.
REQ-038 stall=1 and flush=1 same edge -> bubble; in_use_imm=1, in_imm=0xFFFFFFFC, in_sel=ADD -> data_2=0xFFFFFFFC, sel=4'b0010.
